// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel-to-serial frame serializer for linear layer outputs
//
// Captures a frame of NUM_NODES node values in one cycle and streams them out
// one beat per accepted handshake, node 0 first.
//
// Optional feature macro: SERIALIZER_RELU_EN (beats with a negative buffered
// value are driven as zero; same latency and control in both builds).
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-low reset
//   i_valid   capture request for the frame on din
//   din       NUM_NODES x DATA_WIDTH parallel node values
//   i_ready   a frame can be accepted this cycle (combinational)
//   dout      current beat, zero when o_valid is low
//   o_valid   dout holds a valid beat
//   o_ready   downstream accepts the current beat
//   o_last    current beat is node NUM_NODES-1
//   overflow  sticky: a frame was offered while i_ready was low
`timescale 1ns/1ps
module layer_serializer #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_NODES  = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
   output logic                  i_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic                  o_last,
   output logic                  overflow
);

   localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  ovf_q;
   logic [DATA_WIDTH-1:0] buf_q [NUM_NODES];

   logic                  accept;
   logic                  at_last;
   logic                  capture;
   logic                  drop;
   logic [DATA_WIDTH-1:0] beat;

   // Outputs are decoded from state so an asserted reset clears them at once.
   assign o_valid  = (state_q == STREAM);
   assign at_last  = o_valid && (idx_q == LAST_IDX);
   assign o_last   = at_last;
   assign accept   = o_valid && o_ready;
   // Ready also during the final accepted beat so frames can run back-to-back.
   assign i_ready  = (state_q == IDLE) || (accept && at_last);
   assign capture  = i_valid && i_ready;
   assign drop     = i_valid && !i_ready;
   assign overflow = ovf_q;

`ifdef SERIALIZER_RELU_EN
   assign beat = buf_q[idx_q][DATA_WIDTH-1] ? '0 : buf_q[idx_q];
`else
   assign beat = buf_q[idx_q];
`endif

   assign dout = o_valid ? beat : '0;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d = STREAM;
               idx_d   = '0;
            end
         end
         STREAM: begin
            if (accept) begin
               if (at_last) begin
                  // A capture here restarts the stream with no bubble.
                  state_d = capture ? STREAM : IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Frame buffer carries no reset; it is only observable after a capture.
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_q <= din;
      end
   end

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - self-checking bench for layer_serializer
`timescale 1ns/1ps
module tb_layer_serializer;

   localparam int DW = 8;
   localparam int NN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready = 1'b0;
   logic [DW-1:0] din [NN];
   logic          i_ready;
   logic [DW-1:0] dout;
   logic          o_valid;
   logic          o_last;
   logic          overflow;

   int pass_cnt = 0;
   int total    = 0;

   layer_serializer #(
      .DATA_WIDTH(DW),
      .NUM_NODES (NN)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .din     (din),
      .i_ready (i_ready),
      .dout    (dout),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_last  (o_last),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: the beats still owed downstream, oldest first.
   logic [DW-1:0] exp_q [$];
   bit            ovf_m = 1'b0;

   function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] v);
`ifdef SERIALIZER_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   always @(negedge rst) begin
      exp_q.delete();
      ovf_m = 1'b0;
   end

   always @(posedge clk) begin
      bit rdy;
      if (rst) begin
         rdy = (exp_q.size() == 0) || (o_ready && exp_q.size() == 1);
         if (exp_q.size() > 0 && o_ready) void'(exp_q.pop_front());
         if (i_valid) begin
            if (rdy) for (int k = 0; k < NN; k++) exp_q.push_back(relu_m(din[k]));
            else ovf_m = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         chk("m_o_valid", o_valid, exp_q.size() > 0);
         chk("m_dout", dout, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
         chk("m_o_last", o_last, exp_q.size() == 1);
         chk("m_i_ready", i_ready, (exp_q.size() == 0) || (o_ready && exp_q.size() == 1));
         chk("m_overflow", overflow, ovf_m);
      end
   end

   task automatic step(input bit iv, input bit ordy);
      @(negedge clk);
      i_valid = iv;
      o_ready = ordy;
      #1;
   endtask

   task automatic set_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
      din[0] = a; din[1] = b; din[2] = c; din[3] = d;
   endtask

   task automatic beat(input string name, input logic [DW-1:0] v, input bit last);
      chk({name, "_valid"}, o_valid, 1'b1);
      chk({name, "_dout"}, dout, v);
      chk({name, "_last"}, o_last, last);
   endtask

   logic [DW-1:0] relu_exp [NN];

   initial begin
      set_frame(8'h00, 8'h00, 8'h00, 8'h00);
      #1;
      chk("rst_i_ready", i_ready, 1'b1);
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_o_last", o_last, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Basic frame
      set_frame(8'h11, 8'h22, 8'h33, 8'h44);
      step(1, 1);
      chk("basic_cap_ready", i_ready, 1'b1);
      chk("basic_cap_novalid", o_valid, 1'b0);
      step(0, 1); beat("basic0", 8'h11, 0);
      step(0, 1); beat("basic1", 8'h22, 0);
      step(0, 1); beat("basic2", 8'h33, 0);
      step(0, 1); beat("basic3", 8'h44, 1);
      step(0, 1);
      chk("basic_idle_valid", o_valid, 1'b0);
      chk("basic_idle_ready", i_ready, 1'b1);

      // Backpressure on beat 1
      step(1, 1);
      step(0, 1); beat("bp0", 8'h11, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0); beat("bp_hold", 8'h22, 0);
      end
      step(0, 1); beat("bp1", 8'h22, 0);
      step(0, 1); beat("bp2", 8'h33, 0);
      step(0, 1); beat("bp3", 8'h44, 1);
      step(0, 1);
      chk("bp_idle", o_valid, 1'b0);

      // Back-to-back frames
      step(1, 1);
      step(0, 1); beat("b2b0", 8'h11, 0);
      step(0, 1); beat("b2b1", 8'h22, 0);
      step(0, 1); beat("b2b2", 8'h33, 0);
      set_frame(8'h55, 8'h66, 8'h77, 8'h88);
      step(1, 1); beat("b2b3", 8'h44, 1);
      chk("b2b_ready_on_last", i_ready, 1'b1);
      step(0, 1); beat("b2b_b0", 8'h55, 0);
      step(0, 1); beat("b2b_b1", 8'h66, 0);
      step(0, 1); beat("b2b_b2", 8'h77, 0);
      step(0, 1); beat("b2b_b3", 8'h88, 1);
      step(0, 1);
      chk("b2b_overflow", overflow, 1'b0);

      // Overflow: frame offered during beat 2 is dropped
      set_frame(8'h11, 8'h22, 8'h33, 8'h44);
      step(1, 1);
      step(0, 1); beat("ovf0", 8'h11, 0);
      step(0, 1); beat("ovf1", 8'h22, 0);
      set_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      step(1, 1); beat("ovf2", 8'h33, 0);
      chk("ovf_not_ready", i_ready, 1'b0);
      step(0, 1); beat("ovf3", 8'h44, 1);
      chk("ovf_set", overflow, 1'b1);
      step(0, 1);
      chk("ovf_no_aa", o_valid, 1'b0);
      step(0, 1);
      chk("ovf_sticky", overflow, 1'b1);

      // Reset mid-frame
      set_frame(8'h11, 8'h22, 8'h33, 8'h44);
      step(1, 1);
      step(0, 1); beat("mr0", 8'h11, 0);
      step(0, 1); beat("mr1", 8'h22, 0);
      step(0, 1); beat("mr2", 8'h33, 0);
      #2 rst = 1'b0;
      #1;
      chk("mr_o_valid", o_valid, 1'b0);
      chk("mr_dout", dout, 8'h00);
      chk("mr_overflow", overflow, 1'b0);
      chk("mr_i_ready", i_ready, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      i_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(0, 1);
         chk("mr_quiet", o_valid, 1'b0);
      end

      // Negative-value handling
`ifdef SERIALIZER_RELU_EN
      relu_exp[0] = 8'h7F; relu_exp[1] = 8'h00; relu_exp[2] = 8'h00; relu_exp[3] = 8'h01;
`else
      relu_exp[0] = 8'h7F; relu_exp[1] = 8'h80; relu_exp[2] = 8'hFF; relu_exp[3] = 8'h01;
`endif
      set_frame(8'h7F, 8'h80, 8'hFF, 8'h01);
      step(1, 1);
      for (int i = 0; i < NN; i++) begin
         step(0, 1); beat("relu", relu_exp[i], i == NN - 1);
      end
      step(0, 1);

      // Randomized traffic with one asynchronous reset in the middle
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NN; k++) din[k] = DW'($urandom);
         if (c == 200) begin
            @(negedge clk);
            #3 rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 8; i++) step(0, 1);
      chk("final_idle", o_valid, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
